// File: rtl/tt_um_jimktrains_vslc_pkg.sv
// Shared types and constants for the VSLC scan-cycle controller.
// Covers the controller states, the fault codes and the program header layout.
package tt_um_jimktrains_vslc_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_RUN,
        ST_WRAP,
        ST_HALT,
        ST_FAULT
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE = 2'd0,
        FAULT_HDR  = 2'd1,
        FAULT_WDT  = 2'd2
    } fault_t;

    // Byte offsets of the big-endian start/end words at the top of the EEPROM.
    localparam int HDR_START_HI = 0;
    localparam int HDR_START_LO = 1;
    localparam int HDR_END_HI   = 2;
    localparam int HDR_END_LO   = 3;
    localparam int HDR_LEN      = 4;

endpackage

// File: rtl/tt_um_jimktrains_vslc_in_snapshot.sv
// Per-scan input snapshot: the current and previous samples of ui_in,
// plus the rising/falling edge vectors between the two.
module tt_um_jimktrains_vslc_in_snapshot #(
    parameter int IN_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            capture,
    input  logic [IN_W-1:0] ui_in,
    output logic [IN_W-1:0] in_cur,
    output logic [IN_W-1:0] in_prev,
    output logic [IN_W-1:0] in_rise,
    output logic [IN_W-1:0] in_fall
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; in_prev must see the old in_cur, not ui_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cur  <= '0;
            in_prev <= '0;
        end else if (capture) begin
            in_prev <= in_cur;
            in_cur  <= ui_in;
        end
    end

    assign in_rise = in_cur & ~in_prev;
    assign in_fall = ~in_cur & in_prev;

endmodule

// File: rtl/tt_um_jimktrains_vslc_scan_ctrl.sv
// Scan-cycle controller between the SPI EEPROM reader and the executor: parses
// the program header, forwards in-window bytes and sequences restarts per scan.
module tt_um_jimktrains_vslc_scan_ctrl
    import tt_um_jimktrains_vslc_pkg::*;
#(
    parameter int               ADDR_W    = 9,
    parameter int               IN_W      = 8,
    parameter int               WDT_W     = 16,
    parameter logic [WDT_W-1:0] WDT_LIMIT = 16'hFFFF,
    parameter int               CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    input  logic [7:0]        rd_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_restart,
    output logic [ADDR_W-1:0] rd_start_addr,
    input  logic [IN_W-1:0]   ui_in,
    input  logic              single_step,
    input  logic              step,
    input  logic              clear_fault,
    output logic              instr_valid,
    output logic [7:0]        instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_first,
    output logic              instr_last,
    output logic [IN_W-1:0]   in_cur,
    output logic [IN_W-1:0]   in_prev,
    output logic [IN_W-1:0]   in_rise,
    output logic [IN_W-1:0]   in_fall,
    output logic [CNT_W-1:0]  scan_count,
    output logic              halted,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam logic [WDT_W-1:0] WDT_LAST = WDT_LIMIT - 1'b1;

    state_t            state;
    logic [7:0]        hdr_start_hi;
    logic [7:0]        hdr_start_lo;
    logic [7:0]        hdr_end_hi;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [WDT_W-1:0]  wdt;

    logic [ADDR_W-1:0] new_start;
    logic [ADDR_W-1:0] new_end;
    logic              hdr_bad;
    logic              is_first;
    logic              is_last;
    logic              in_window;
    logic              accept;
    logic              wdt_active;
    logic              wdt_expire;

    // The end word completes with the byte arriving now, so validate it directly.
    assign new_start = ADDR_W'({hdr_start_hi, hdr_start_lo});
    assign new_end   = ADDR_W'({hdr_end_hi, rd_data});
    assign hdr_bad   = (new_start < ADDR_W'(HDR_LEN)) || (new_end < new_start) || (new_end == '0);

    assign is_first  = (rd_addr == start_addr);
    assign is_last   = (rd_addr == end_addr);
    assign in_window = (rd_addr >= start_addr) && (rd_addr <= end_addr);

    // WRAP only picks up the start byte; from there it behaves exactly like RUN.
    assign accept = rd_valid && (((state == ST_RUN) && in_window) ||
                                 ((state == ST_WRAP) && is_first));

    assign wdt_active = (state == ST_HDR) || (state == ST_RUN) || (state == ST_WRAP);
    assign wdt_expire = wdt_active && !rd_valid && (wdt == WDT_LAST);

    tt_um_jimktrains_vslc_in_snapshot #(
        .IN_W (IN_W)
    ) u_in_snapshot (
        .clk     (clk),
        .rst     (rst),
        .capture (accept && is_first),
        .ui_in   (ui_in),
        .in_cur  (in_cur),
        .in_prev (in_prev),
        .in_rise (in_rise),
        .in_fall (in_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_HDR;
            hdr_start_hi  <= '0;
            hdr_start_lo  <= '0;
            hdr_end_hi    <= '0;
            start_addr    <= '0;
            end_addr      <= '0;
            wdt           <= '0;
            rd_restart    <= 1'b0;
            rd_start_addr <= '0;
            instr_valid   <= 1'b0;
            instr_data    <= '0;
            instr_addr    <= '0;
            instr_first   <= 1'b0;
            instr_last    <= 1'b0;
            scan_count    <= '0;
            halted        <= 1'b0;
            fault         <= 1'b0;
            fault_code    <= FAULT_NONE;
        end else begin
            instr_valid <= 1'b0;
            instr_first <= 1'b0;
            instr_last  <= 1'b0;
            rd_restart  <= 1'b0;

            if (!wdt_active || rd_valid) begin
                wdt <= '0;
            end else begin
                wdt <= wdt + 1'b1;
            end

            if (accept) begin
                instr_valid <= 1'b1;
                instr_data  <= rd_data;
                instr_addr  <= rd_addr;
                instr_first <= is_first;
                instr_last  <= is_last;
            end

            case (state)
                ST_HDR: begin
                    if (rd_valid) begin
                        if (rd_addr == ADDR_W'(HDR_START_HI)) begin
                            hdr_start_hi <= rd_data;
                        end else if (rd_addr == ADDR_W'(HDR_START_LO)) begin
                            hdr_start_lo <= rd_data;
                        end else if (rd_addr == ADDR_W'(HDR_END_HI)) begin
                            hdr_end_hi <= rd_data;
                        end else if (rd_addr == ADDR_W'(HDR_END_LO)) begin
                            if (hdr_bad) begin
                                state      <= ST_FAULT;
                                fault      <= 1'b1;
                                fault_code <= FAULT_HDR;
                            end else begin
                                start_addr    <= new_start;
                                end_addr      <= new_end;
                                rd_start_addr <= new_start;
                                state         <= ST_RUN;
                            end
                        end
                    end else if (wdt_expire) begin
                        state      <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_code <= FAULT_WDT;
                        wdt        <= '0;
                    end
                end

                ST_RUN, ST_WRAP: begin
                    if (accept && is_last) begin
                        scan_count <= scan_count + 1'b1;
                        if (single_step) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else begin
                            rd_restart <= 1'b1;
                            state      <= ST_WRAP;
                        end
                    end else if (accept) begin
                        state <= ST_RUN;
                    end else if (wdt_expire) begin
                        state      <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_code <= FAULT_WDT;
                        wdt        <= '0;
                    end
                end

                ST_HALT: begin
                    if (step) begin
                        rd_restart <= 1'b1;
                        halted     <= 1'b0;
                        state      <= ST_WRAP;
                    end
                end

                ST_FAULT: begin
                    // Snapshot and scan count survive; only the header is re-read.
                    if (clear_fault) begin
                        rd_start_addr <= '0;
                        rd_restart    <= 1'b1;
                        fault         <= 1'b0;
                        fault_code    <= FAULT_NONE;
                        state         <= ST_HDR;
                    end
                end

                default: state <= ST_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_scan_ctrl.sv
// Directed bench for the VSLC scan controller: header parsing, windowing,
// restart sequencing, single-step, watchdog, fault recovery and async reset.
module tb_tt_um_jimktrains_vslc_scan_ctrl;

    localparam int ADDR_W = 9;
    localparam int IN_W   = 8;
    localparam int WDT_W  = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_valid;
    logic [7:0]        rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_restart;
    logic [ADDR_W-1:0] rd_start_addr;
    logic [IN_W-1:0]   ui_in;
    logic              single_step;
    logic              step;
    logic              clear_fault;
    logic              instr_valid;
    logic [7:0]        instr_data;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_first;
    logic              instr_last;
    logic [IN_W-1:0]   in_cur;
    logic [IN_W-1:0]   in_prev;
    logic [IN_W-1:0]   in_rise;
    logic [IN_W-1:0]   in_fall;
    logic [CNT_W-1:0]  scan_count;
    logic              halted;
    logic              fault;
    logic [1:0]        fault_code;

    int total = 0;
    int bad   = 0;
    int n_valid;

    tt_um_jimktrains_vslc_scan_ctrl #(
        .ADDR_W    (ADDR_W),
        .IN_W      (IN_W),
        .WDT_W     (WDT_W),
        .WDT_LIMIT (16'd20),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_addr       (rd_addr),
        .rd_restart    (rd_restart),
        .rd_start_addr (rd_start_addr),
        .ui_in         (ui_in),
        .single_step   (single_step),
        .step          (step),
        .clear_fault   (clear_fault),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_addr    (instr_addr),
        .instr_first   (instr_first),
        .instr_last    (instr_last),
        .in_cur        (in_cur),
        .in_prev       (in_prev),
        .in_rise       (in_rise),
        .in_fall       (in_fall),
        .scan_count    (scan_count),
        .halted        (halted),
        .fault         (fault),
        .fault_code    (fault_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One reader byte for one cycle; returns just after the capturing edge.
    task automatic drive(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        @(negedge clk);
        rd_valid = 1'b1;
        rd_addr  = a;
        rd_data  = d;
        @(posedge clk);
        #1;
        if (instr_valid) n_valid++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rd_valid = 1'b0;
            @(posedge clk);
            #1;
            if (instr_valid) n_valid++;
        end
    endtask

    task automatic pulse_step();
        @(negedge clk);
        rd_valid = 1'b0;
        step     = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        rd_valid    = 1'b0;
        clear_fault = 1'b1;
        @(posedge clk);
        #1;
        clear_fault = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic header(input logic [15:0] s, input logic [15:0] e);
        drive(9'd0, s[15:8]);
        drive(9'd1, s[7:0]);
        drive(9'd2, e[15:8]);
        drive(9'd3, e[7:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rd_valid = 1'b0; rd_data = '0; rd_addr = '0;
        ui_in = '0; single_step = 1'b0; step = 1'b0; clear_fault = 1'b0;
        n_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", instr_valid, 0);
        check("rst_restart", rd_restart, 0);
        check("rst_start", rd_start_addr, 0);
        check("rst_count", scan_count, 0);
        check("rst_cur", in_cur, 0);
        check("rst_flags", {halted, fault, fault_code}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Scan window 4..7, free-running.
        ui_in = 8'h5A;
        header(16'h0004, 16'h0007);
        check("t1_start", rd_start_addr, 4);
        check("t1_hdr_fault", fault, 0);
        n_valid = 0;
        drive(9'd4, 8'hA0);
        check("t1_a0", {instr_valid, instr_first, instr_last, instr_addr, instr_data}, {1'b1, 1'b1, 1'b0, 9'd4, 8'hA0});
        check("t1_cur", in_cur, 8'h5A);
        drive(9'd5, 8'hA1);
        check("t1_a1", {instr_valid, instr_first, instr_data}, {1'b1, 1'b0, 8'hA1});
        drive(9'd6, 8'hA2);
        drive(9'd7, 8'hA3);
        check("t1_a3", {instr_valid, instr_last, instr_data, rd_restart}, {1'b1, 1'b1, 8'hA3, 1'b1});
        check("t1_count", scan_count, 1);
        check("t1_nvalid", n_valid, 4);
        idle(1);
        check("t1_restart_once", rd_restart, 0);
        drive(9'd8, 8'hFF);
        check("t1_wrap_discard", instr_valid, 0);
        ui_in = 8'h33;
        drive(9'd4, 8'hB0);
        check("t1_b0", {instr_valid, instr_first, instr_data}, {1'b1, 1'b1, 8'hB0});
        check("t1_snap", {in_cur, in_prev}, {8'h33, 8'h5A});
        drive(9'd5, 8'hB1);
        drive(9'd6, 8'hB2);
        drive(9'd7, 8'hB3);
        check("t1_scan2", {instr_last, rd_restart, scan_count}, {1'b1, 1'b1, 16'd2});

        // Async reset in the middle of the third scan.
        drive(9'd4, 8'hC0);
        check("t6_pre", instr_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async", instr_valid, 0);
        @(negedge clk);
        rd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t6_next", {instr_valid, rd_start_addr}, 0);
        check("t6_state", {scan_count, in_cur, in_prev}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Skip gap: window 8..9 with filler at 4..7.
        header(16'h0008, 16'h0009);
        check("t2_start", rd_start_addr, 8);
        n_valid = 0;
        for (int a = 4; a < 8; a++) drive(ADDR_W'(a), 8'hEE);
        check("t2_gap", n_valid, 0);
        drive(9'd8, 8'h18);
        check("t2_a8", {instr_valid, instr_first, instr_addr}, {1'b1, 1'b1, 9'd8});
        drive(9'd9, 8'h19);
        check("t2_a9", {instr_valid, instr_last, instr_addr, rd_restart}, {1'b1, 1'b1, 9'd9, 1'b1});
        check("t2_count", scan_count, 1);

        // Bad header (end < start) and fault recovery.
        do_reset();
        n_valid = 0;
        header(16'h0006, 16'h0005);
        check("t3_fault", {fault, fault_code}, {1'b1, 2'd1});
        drive(9'd6, 8'h66);
        idle(25);
        check("t3_sticky", {fault, fault_code}, {1'b1, 2'd1});
        check("t3_nvalid", n_valid, 0);
        pulse_clear();
        check("t3_clear", {rd_restart, rd_start_addr, fault, fault_code}, {1'b1, 9'd0, 1'b0, 2'd0});
        idle(1);
        check("t3_restart_once", rd_restart, 0);

        // Single-step across two scans.
        single_step = 1'b1;
        ui_in = 8'h01;
        header(16'h0004, 16'h0005);
        drive(9'd4, 8'hD0);
        check("t4_d0", {instr_valid, instr_first, in_cur}, {1'b1, 1'b1, 8'h01});
        drive(9'd5, 8'hD1);
        check("t4_halt", {instr_last, halted, rd_restart}, {1'b1, 1'b1, 1'b0});
        check("t4_count", scan_count, 1);
        n_valid = 0;
        drive(9'd6, 8'h77);
        drive(9'd4, 8'h78);
        idle(30);
        check("t4_stray", n_valid, 0);
        check("t4_hold", {halted, fault}, {1'b1, 1'b0});
        ui_in = 8'h03;
        pulse_step();
        check("t4_step", {rd_restart, halted}, {1'b1, 1'b0});
        drive(9'd4, 8'hE0);
        check("t4_e0", {instr_valid, instr_first, instr_data}, {1'b1, 1'b1, 8'hE0});
        check("t4_edges", {in_cur, in_prev, in_rise, in_fall}, {8'h03, 8'h01, 8'h02, 8'h00});
        drive(9'd5, 8'hE1);
        check("t4_halt2", {halted, rd_restart, scan_count}, {1'b1, 1'b0, 16'd2});

        // Watchdog: a byte in the expiry cycle wins, silence then faults.
        single_step = 1'b0;
        pulse_step();
        drive(9'd4, 8'hF0);
        idle(19);
        check("t5_no_fault", fault, 0);
        drive(9'd5, 8'hF1);
        check("t5_byte_wins", {instr_valid, fault, rd_restart}, {1'b1, 1'b0, 1'b1});
        check("t5_count", scan_count, 3);
        idle(19);
        check("t5_edge", fault, 0);
        idle(1);
        check("t5_wdt", {fault, fault_code}, {1'b1, 2'd2});
        pulse_step();
        check("t5_step_ignored", {rd_restart, fault, halted}, {1'b0, 1'b1, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
